fmc_adc_acq_sequencer: RTL
==========================

// Module: fmc_adc_acq_sequencer
// PURPOSE
//  Acquisition sequencer for the FMC-ADC 100Ms core. Runs single-shot and multi-shot captures:
//  counts pre-/post-trigger samples, arbitrates when a qualified trigger is accepted,
//  decrements the shot counter and reports state, config validity and end-of-acquisition.
//  Sits between the CSR block (config, start/stop), the trigger unit and the sample write path.
// PARAMETERS
//  g_multishot_ram_size  2048  depth (samples) of one multi-shot buffer; bounds pre+post when shots>1
//  g_shots_width         16    width of shot counter
//  g_cnt_width           32    width of pre/post sample counters
// PORTS
//  sys_clk_i           in   1              system clock
//  sys_rst_n_i         in   1              asynchronous reset, active-low
//  start_i             in   1              FSM start pulse (CSR CTL write)
//  stop_i              in   1              FSM stop pulse
//  pre_samples_i       in   g_cnt_width    pre-trigger sample count
//  post_samples_i      in   g_cnt_width    post-trigger sample count (trigger sample included)
//  shots_i             in   g_shots_width  number of shots
//  samples_valid_i     in   1              one-cycle strobe per sample from the ADC datapath
//  trig_i              in   1              qualified trigger; meaningful only with samples_valid_i
//  samples_wr_en_o     out  1              write current sample to acquisition memory
//  trig_accepted_o     out  1              pulse: trigger taken in WAIT_TRIG
//  tag_wr_o            out  1              pulse: write trigger timetag after shot's last sample
//  shot_end_o          out  1              pulse: shot finished, more shots remain
//  acq_end_o           out  1              pulse: last shot finished (acq_end irq)
//  shots_remaining_o   out  g_shots_width  shots still to capture
//  cfg_ok_o            out  1              current config is valid
//  fsm_state_o         out  3              state encoding, see below
// BEHAVIOUR
//  Reset: all pulses 0, samples_wr_en_o=0, shots_remaining_o=0, cfg_ok_o=0, fsm_state_o=1 (IDLE).
//  cfg_ok_o (registered, 1-cycle latency) = post!=0 && shots!=0 && (shots==1 || pre+post<=g_multishot_ram_size);
//   pre+post evaluated in g_cnt_width+1 bits (no wrap).
//  States: 1 IDLE, 2 PRE_TRIG, 3 WAIT_TRIG, 4 POST_TRIG, 5 TRIG_TAG, 6 DECR_SHOT (others unused -> IDLE).
//  IDLE: start_i && cfg_ok_o -> PRE_TRIG; latch pre/post/shots; shots_remaining_o=shots_i. Start otherwise ignored.
//  PRE_TRIG: count samples_valid_i up to pre; at count==pre -> WAIT_TRIG. pre==0 -> WAIT_TRIG next cycle.
//   trig_i here is ignored (no trig_accepted_o).
//  WAIT_TRIG: trig_i && samples_valid_i -> trig_accepted_o=1 same cycle as registered pulse, that sample
//   counts as post sample 1; post==1 -> TRIG_TAG, else POST_TRIG.
//  POST_TRIG: count samples until post reached -> TRIG_TAG. Further trig_i ignored.
//  TRIG_TAG: tag_wr_o=1 for one cycle -> DECR_SHOT.
//  DECR_SHOT: shots_remaining_o-=1; result 0 -> acq_end_o, IDLE; else shot_end_o, PRE_TRIG (pre counter cleared).
//  samples_wr_en_o = samples_valid_i in PRE_TRIG/WAIT_TRIG/POST_TRIG only (combinational on state reg);
//   samples during TRIG_TAG/DECR_SHOT are not written.
//  All pulse outputs registered, exactly one cycle wide; config inputs ignored outside IDLE.
//  stop_i: any state -> IDLE next cycle, counters cleared, shots_remaining_o=0, no acq_end_o/tag_wr_o.
//  start_i and stop_i same cycle: stop wins. Async reset mid-acquisition: immediate return to reset values.
// TESTING
//  1 Reset, shots=1 pre=0 post=1 -> fsm_state_o=1, cfg_ok_o=1 two cycles after reset release.
//  2 Single shot pre=0 post=1, start, trig with valid -> trig_accepted_o, tag_wr_o, acq_end_o once; IDLE;
//    exactly 1 write after the trigger.
//  3 shots=3 pre=2 post=4, three triggers -> 3 trig_accepted, 3 tag_wr, 2 shot_end, 1 acq_end;
//    shots_remaining 3->0.
//  4 trig_i during PRE_TRIG (pre=16) -> no trig_accepted_o; next trig in WAIT_TRIG accepted.
//  5 stop_i in POST_TRIG (post=128, 10 samples in) -> IDLE next cycle, no tag_wr_o/acq_end_o, shots_remaining=0.
//  6 shots=3 pre=1000 post=1049 -> cfg_ok_o=0, start ignored (state 1); post=1048 -> cfg_ok_o=1, start accepted.

Source files
------------

// File: rtl/fmc_adc_acq_sequencer.sv
// Acquisition sequencer for the FMC-ADC 100Ms core: pre/post-trigger sample
// counting, trigger acceptance, multi-shot bookkeeping and end-of-acquisition.
module fmc_adc_acq_sequencer #(
    parameter int g_multishot_ram_size = 2048,
    parameter int g_shots_width        = 16,
    parameter int g_cnt_width          = 32
) (
    input  logic                     sys_clk_i,
    input  logic                     sys_rst_n_i,
    input  logic                     start_i,
    input  logic                     stop_i,
    input  logic [g_cnt_width-1:0]   pre_samples_i,
    input  logic [g_cnt_width-1:0]   post_samples_i,
    input  logic [g_shots_width-1:0] shots_i,
    input  logic                     samples_valid_i,
    input  logic                     trig_i,
    output logic                     samples_wr_en_o,
    output logic                     trig_accepted_o,
    output logic                     tag_wr_o,
    output logic                     shot_end_o,
    output logic                     acq_end_o,
    output logic [g_shots_width-1:0] shots_remaining_o,
    output logic                     cfg_ok_o,
    output logic [2:0]               fsm_state_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd1,
        S_PRE_TRIG  = 3'd2,
        S_WAIT_TRIG = 3'd3,
        S_POST_TRIG = 3'd4,
        S_TRIG_TAG  = 3'd5,
        S_DECR_SHOT = 3'd6
    } state_t;

    localparam logic [g_cnt_width-1:0]   C_CNT_ONE  = g_cnt_width'(1);
    localparam logic [g_shots_width-1:0] C_SHOT_ONE = g_shots_width'(1);
    localparam logic [g_cnt_width:0]     C_RAM_SIZE = (g_cnt_width+1)'(g_multishot_ram_size);

    state_t                   r_state, w_next;
    logic [g_cnt_width-1:0]   r_pre, r_post;
    logic [g_cnt_width-1:0]   r_pre_cnt, w_pre_cnt_nxt;
    logic [g_cnt_width-1:0]   r_post_cnt, w_post_cnt_nxt;
    logic [g_shots_width-1:0] r_shots_rem, w_shots_nxt;
    logic                     r_cfg_ok, w_cfg_ok;
    logic                     w_latch;
    logic                     r_trig_acc, w_trig_acc_nxt;
    logic                     r_tag_wr, w_tag_wr_nxt;
    logic                     r_shot_end, w_shot_end_nxt;
    logic                     r_acq_end, w_acq_end_nxt;
    logic [g_cnt_width:0]     w_cfg_sum;
    logic [g_cnt_width-1:0]   w_pre_inc, w_post_inc;

    // Sum kept one bit wider so huge pre/post values cannot wrap into a valid config.
    assign w_cfg_sum = {1'b0, pre_samples_i} + {1'b0, post_samples_i};
    assign w_cfg_ok  = (post_samples_i != '0) && (shots_i != '0) &&
                       ((shots_i == C_SHOT_ONE) || (w_cfg_sum <= C_RAM_SIZE));

    assign w_pre_inc  = r_pre_cnt + C_CNT_ONE;
    assign w_post_inc = r_post_cnt + C_CNT_ONE;

    always_comb begin
        w_next         = r_state;
        w_pre_cnt_nxt  = r_pre_cnt;
        w_post_cnt_nxt = r_post_cnt;
        w_shots_nxt    = r_shots_rem;
        w_latch        = 1'b0;
        w_trig_acc_nxt = 1'b0;
        w_shot_end_nxt = 1'b0;
        w_acq_end_nxt  = 1'b0;
        if (stop_i) begin
            w_next         = S_IDLE;
            w_pre_cnt_nxt  = '0;
            w_post_cnt_nxt = '0;
            w_shots_nxt    = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_pre_cnt_nxt  = '0;
                    w_post_cnt_nxt = '0;
                    if (start_i && r_cfg_ok) begin
                        w_next      = S_PRE_TRIG;
                        w_latch     = 1'b1;
                        w_shots_nxt = shots_i;
                    end
                end
                S_PRE_TRIG: begin
                    if (r_pre == '0) begin
                        w_next = S_WAIT_TRIG;
                    end else if (samples_valid_i) begin
                        w_pre_cnt_nxt = w_pre_inc;
                        if (w_pre_inc == r_pre) w_next = S_WAIT_TRIG;
                    end
                end
                S_WAIT_TRIG: begin
                    if (samples_valid_i && trig_i) begin
                        w_trig_acc_nxt = 1'b1;
                        w_post_cnt_nxt = C_CNT_ONE;
                        w_next         = (r_post == C_CNT_ONE) ? S_TRIG_TAG : S_POST_TRIG;
                    end
                end
                S_POST_TRIG: begin
                    if (samples_valid_i) begin
                        w_post_cnt_nxt = w_post_inc;
                        if (w_post_inc == r_post) w_next = S_TRIG_TAG;
                    end
                end
                S_TRIG_TAG: begin
                    w_next = S_DECR_SHOT;
                end
                S_DECR_SHOT: begin
                    w_shots_nxt    = r_shots_rem - C_SHOT_ONE;
                    w_pre_cnt_nxt  = '0;
                    w_post_cnt_nxt = '0;
                    if (r_shots_rem <= C_SHOT_ONE) begin
                        w_acq_end_nxt = 1'b1;
                        w_next        = S_IDLE;
                    end else begin
                        w_shot_end_nxt = 1'b1;
                        w_next         = S_PRE_TRIG;
                    end
                end
                default: begin
                    w_next = S_IDLE;
                end
            endcase
        end
    end

    // Tag pulse is registered on entry so it lines up with the TRIG_TAG state.
    assign w_tag_wr_nxt = (w_next == S_TRIG_TAG);

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            r_state     <= S_IDLE;
            r_pre       <= '0;
            r_post      <= '0;
            r_pre_cnt   <= '0;
            r_post_cnt  <= '0;
            r_shots_rem <= '0;
            r_cfg_ok    <= 1'b0;
            r_trig_acc  <= 1'b0;
            r_tag_wr    <= 1'b0;
            r_shot_end  <= 1'b0;
            r_acq_end   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_pre_cnt   <= w_pre_cnt_nxt;
            r_post_cnt  <= w_post_cnt_nxt;
            r_shots_rem <= w_shots_nxt;
            r_cfg_ok    <= w_cfg_ok;
            r_trig_acc  <= w_trig_acc_nxt;
            r_tag_wr    <= w_tag_wr_nxt;
            r_shot_end  <= w_shot_end_nxt;
            r_acq_end   <= w_acq_end_nxt;
            if (w_latch) begin
                r_pre  <= pre_samples_i;
                r_post <= post_samples_i;
            end
        end
    end

    assign samples_wr_en_o   = samples_valid_i &&
                               ((r_state == S_PRE_TRIG) || (r_state == S_WAIT_TRIG) ||
                                (r_state == S_POST_TRIG));
    assign trig_accepted_o   = r_trig_acc;
    assign tag_wr_o          = r_tag_wr;
    assign shot_end_o        = r_shot_end;
    assign acq_end_o         = r_acq_end;
    assign shots_remaining_o = r_shots_rem;
    assign cfg_ok_o          = r_cfg_ok;
    assign fsm_state_o       = r_state;

endmodule
